op_dual_mac16: RTL and testbench

OP_DUAL_MAC16 -- requirements
Module: op_dual_mac16

---
 rtl/op_dmac_pkg.sv | 15 +
 rtl/seq_mul_signed.sv | 53 +++++
 rtl/op_dual_mac16.sv | 112 +++++++++++
 tb/tb_op_dual_mac16.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/op_dmac_pkg.sv
// rtl/op_dmac_pkg.sv - shared state encoding, width default and latency for the dual MAC.
package op_dmac_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LAT = 2 * DATA_W_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL1 = 3'd1,
    ST_MUL2 = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/seq_mul_signed.sv
// rtl/seq_mul_signed.sv - signed shift-add multiplier, one partial product per cycle.
module seq_mul_signed #(
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic                       busy,
  output logic                       done,
  output logic signed [2*DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]              cnt;
  logic [CW-1:0]              idx;
  logic signed [2*DATA_W-1:0] acc;
  logic signed [2*DATA_W-1:0] base;
  logic signed [2*DATA_W-1:0] pp;

  // Iteration 0 runs on the start edge itself, so the product is ready after exactly DATA_W edges.
  always_comb begin
    idx  = busy ? cnt : '0;
    base = busy ? acc : '0;
    pp   = b[idx] ? ({{DATA_W{a[DATA_W-1]}}, a} <<< idx) : '0;
    // The multiplier's top bit carries weight -2^(DATA_W-1), so its partial product is subtracted.
    product = (idx == CW'(DATA_W - 1)) ? (base - pp) : (base + pp);
    done    = busy && (cnt == CW'(DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      acc <= product;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (start) begin
      acc  <= product;
      cnt  <= CW'(1);
      busy <= 1'b1;
    end
  end

endmodule

// File: rtl/op_dual_mac16.sv
// rtl/op_dual_mac16.sv - sequential a*b + c*d with overflow flag and strobe/ack handshake.
// Define OP_DMAC_SAT_EN to saturate the result on overflow instead of wrapping.
module op_dual_mac16
  import op_dmac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic [DATA_W-1:0] input_c,
  input  logic [DATA_W-1:0] input_d,
  input  logic              in_stb,
  output logic              in_busy,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              out_stb,
  input  logic              out_ack
);

  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] MUL1 = ST_MUL1;
  localparam logic [2:0] MUL2 = ST_MUL2;
  localparam logic [2:0] ADD  = ST_ADD;
  localparam logic [2:0] DONE = ST_DONE;

  logic [2:0]                 state;
  logic signed [DATA_W-1:0]   a_r, b_r, c_r, d_r;
  logic signed [DATA_W-1:0]   mul_a, mul_b;
  logic signed [2*DATA_W-1:0] p1, p2, mul_prod;
  logic signed [2*DATA_W:0]   sum;
  logic                       mul_start, mul_busy, mul_done;
  logic                       sum_ovf;
  logic [DATA_W-1:0]          sum_res;

  always_comb begin
    mul_a     = (state == MUL2) ? c_r : a_r;
    mul_b     = (state == MUL2) ? d_r : b_r;
    mul_start = ((state == MUL1) || (state == MUL2)) && !mul_busy;
    sum       = {p1[2*DATA_W-1], p1} + {p2[2*DATA_W-1], p2};
    // In range only when every bit from the sign down to bit DATA_W-1 agrees.
    sum_ovf   = !((&sum[2*DATA_W:DATA_W-1]) || !(|sum[2*DATA_W:DATA_W-1]));
`ifdef OP_DMAC_SAT_EN
    if (sum_ovf)
      sum_res = sum[2*DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sum_res = sum[DATA_W-1:0];
`else
    sum_res = sum[DATA_W-1:0];
`endif
  end

  seq_mul_signed #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= '0;
      d_r     <= '0;
      p1      <= '0;
      p2      <= '0;
      in_busy <= 1'b0;
      out_stb <= 1'b0;
      ovf     <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (in_stb) begin
          a_r     <= input_a;
          b_r     <= input_b;
          c_r     <= input_c;
          d_r     <= input_d;
          in_busy <= 1'b1;
          state   <= MUL1;
        end
        MUL1: if (mul_done) begin
          p1    <= mul_prod;
          state <= MUL2;
        end
        MUL2: if (mul_done) begin
          p2    <= mul_prod;
          state <= ADD;
        end
        ADD: begin
          result  <= sum_res;
          ovf     <= sum_ovf;
          out_stb <= 1'b1;
          state   <= DONE;
        end
        DONE: if (out_ack) begin
          out_stb <= 1'b0;
          in_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_dual_mac16.sv
// tb/tb_op_dual_mac16.sv - scoreboard bench for op_dual_mac16.
module tb_op_dual_mac16;

  localparam int EXP_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] input_a, input_b, input_c, input_d;
  logic        in_stb, out_ack;
  logic        in_busy, ovf, out_stb;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;
  logic [16:0] sb[$];

  op_dual_mac16 #(.DATA_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .input_a (input_a),
    .input_b (input_b),
    .input_c (input_c),
    .input_d (input_d),
    .in_stb  (in_stb),
    .in_busy (in_busy),
    .result  (result),
    .ovf     (ovf),
    .out_stb (out_stb),
    .out_ack (out_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, b, c, d);
    longint s;
    logic [15:0] r;
    logic o;
    s = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c)) * longint'($signed(d));
    o = (s > 32767) || (s < -32768);
    r = s[15:0];
`ifdef OP_DMAC_SAT_EN
    if (o) r = (s < 0) ? 16'h8000 : 16'h7FFF;
`endif
    return {o, r};
  endfunction

  task automatic set_ops(input logic [15:0] a, b, c, d);
    input_a = a; input_b = b; input_c = c; input_d = d;
  endtask

  task automatic wait_and_pop(input string name);
    int n;
    logic [16:0] exp;
    n = 0;
    while (out_stb !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== EXP_LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, EXP_LAT);
    end
    exp = sb.pop_front();
    checks++;
    if (result !== exp[15:0]) begin
      failures++;
      $display("FAIL %s result: got %h, expected %h", name, result, exp[15:0]);
    end
    checks++;
    if (ovf !== exp[16]) begin
      failures++;
      $display("FAIL %s ovf: got %b, expected %b", name, ovf, exp[16]);
    end
  endtask

  task automatic run_op(input logic [15:0] a, b, c, d, input logic [15:0] er, input logic eo,
                        input string name);
    sb.push_back({eo, er});
    set_ops(a, b, c, d);
    in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    checks++;
    if (in_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_on_accept: got %b, expected 1", name, in_busy);
    end
    wait_and_pop(name);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    checks++;
    if (out_stb !== 1'b0 || in_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_clear: got out_stb=%b in_busy=%b, expected 0 0", name, out_stb, in_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_busy, out_stb, ovf, result} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b stb=%b ovf=%b result=%h, expected all 0",
               in_busy, out_stb, ovf, result);
    end
    rst = 1'b1;
    // in_stb rises together with rst, so the first edge with rst high must accept it
    run_op(16'd3, 16'd4, 16'd5, 16'd6, 16'h002A, 1'b0, "first_after_reset");
  endtask

  task automatic test_spec_vectors();
    run_op(16'hFFFE, 16'd7, 16'd100, 16'hFFFD, 16'hFEC6, 1'b0, "neg_mix");
`ifdef OP_DMAC_SAT_EN
    run_op(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, "all_min");
`else
    run_op(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b1, "all_min");
`endif
    run_op(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8001, 1'b0, "max_min");
  endtask

  task automatic test_random();
    logic [15:0] a, b, c, d;
    logic [16:0] m;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      c = 16'($urandom); d = 16'($urandom);
      if (i == 0) begin a = 16'h8000; b = 16'h8001; end
      m = model(a, b, c, d);
      run_op(a, b, c, d, m[15:0], m[16], "random");
    end
  endtask

  task automatic test_hold_and_back_to_back();
    int n;
    sb.push_back({1'b0, 16'h001A});
    set_ops(16'd2, 16'd3, 16'd4, 16'd5);
    in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    set_ops(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    n = 4;
    while (out_stb !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== EXP_LAT) begin
      failures++;
      $display("FAIL hold latency: got %0d cycles, expected %0d", n, EXP_LAT);
    end
    for (int k = 0; k < 10; k++) begin
      in_stb = k[0];
      @(posedge clk); #1;
      checks++;
      if (out_stb !== 1'b1 || in_busy !== 1'b1 || result !== sb[0][15:0] || ovf !== sb[0][16]) begin
        failures++;
        $display("FAIL hold_stable: got stb=%b busy=%b result=%h ovf=%b, expected 1 1 %h %b",
                 out_stb, in_busy, result, ovf, sb[0][15:0], sb[0][16]);
      end
    end
    void'(sb.pop_front());
    sb.push_back({1'b0, 16'h002A});
    set_ops(16'd3, 16'd4, 16'd5, 16'd6);
    in_stb = 1'b1;
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    checks++;
    if (out_stb !== 1'b0 || in_busy !== 1'b0) begin
      failures++;
      $display("FAIL ack_wins: got out_stb=%b in_busy=%b, expected 0 0", out_stb, in_busy);
    end
    @(posedge clk); #1;
    in_stb = 1'b0;
    checks++;
    if (in_busy !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_accept: got in_busy=%b, expected 1", in_busy);
    end
    wait_and_pop("back_to_back");
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    // leave a non-zero result with ovf set so the reset clear is observable
    run_op(16'h8000, 16'h8000, 16'h8000, 16'h8000,
`ifdef OP_DMAC_SAT_EN
           16'h7FFF,
`else
           16'h0000,
`endif
           1'b1, "pre_reset");
    run_op(16'd1, 16'd1, 16'd1, 16'd2, 16'h0003, 1'b0, "pre_reset_nz");
    set_ops(16'd9, 16'd9, 16'd9, 16'd9);
    in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_busy, out_stb, ovf, result} !== 19'd0) begin
      failures++;
      $display("FAIL mid_reset_clear: got busy=%b stb=%b ovf=%b result=%h, expected all 0",
               in_busy, out_stb, ovf, result);
    end
    rst = 1'b1;
    run_op(16'd3, 16'd4, 16'd5, 16'd6, 16'h002A, 1'b0, "after_mid_reset");
  endtask

  initial begin
    rst = 1'b0;
    in_stb = 1'b0;
    out_ack = 1'b0;
    set_ops(16'd0, 16'd0, 16'd0, 16'd0);
    test_reset();
    test_spec_vectors();
    test_random();
    test_hold_and_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
